// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter for a shared sequential ALU
// Grants one requester at a time, issues the command, waits for the ALU response or a timeout, then returns it.
module alu_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic [1:0] sel0,
   input  logic       req1,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   input  logic [1:0] sel1,
   output logic       done0,
   output logic       done1,
   output logic [3:0] result_out,
   output logic       err,
   output logic       busy,
   output logic       alu_start,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [1:0] alu_sel,
   input  logic [3:0] alu_result,
   input  logic       alu_ready
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   // Counter value seen on the last permitted WAIT cycle.
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   logic [1:0] state;
   logic [7:0] wait_cnt;
   logic       owner;
   logic       last_grant;
   logic       grant_valid;
   logic       grant_id;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant_valid = req0 | req1;
      grant_id    = (req0 & req1) ? ~last_grant : req1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         done0      <= 1'b0;
         done1      <= 1'b0;
         result_out <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
         alu_start  <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner      <= grant_id;
                  last_grant <= grant_id;
                  alu_a      <= grant_id ? a1 : a0;
                  alu_b      <= grant_id ? b1 : b0;
                  alu_sel    <= grant_id ? sel1 : sel0;
                  alu_start  <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               alu_start <= 1'b0;
               wait_cnt  <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               if (alu_ready) begin
                  result_out <= alu_result;
                  err        <= 1'b0;
                  done0      <= ~owner;
                  done1      <= owner;
                  state      <= RESP;
               end else if (wait_cnt == LAST_WAIT) begin
                  result_out <= '0;
                  err        <= 1'b1;
                  done0      <= ~owner;
                  done1      <= owner;
                  state      <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: begin
               done0      <= 1'b0;
               done1      <= 1'b0;
               result_out <= '0;
               err        <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
// Responds to alu_start with a configurable-latency ALU model; expected results are hand-computed constants.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [3:0] a0, b0, a1, b1;
   logic [1:0] sel0, sel1;
   logic       done0, done1, err, busy, alu_start, alu_ready;
   logic [3:0] result_out, alu_a, alu_b, alu_result;
   logic [1:0] alu_sel;

   int passed = 0;
   int total  = 0;

   // ALU model: ready arrives alu_delay cycles after the alu_start cycle (alu_delay >= 2).
   int         alu_delay = 3;
   bit         alu_never = 1'b0;
   int         m_cnt;
   bit         m_pend;
   logic [3:0] m_res;

   alu_arbiter #(.TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0), .sel0(sel0),
      .req1(req1), .a1(a1), .b1(b1), .sel1(sel1),
      .done0(done0), .done1(done1), .result_out(result_out), .err(err), .busy(busy),
      .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_ready(alu_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      alu_ready <= 1'b0;
      if (rst) begin
         m_pend     <= 1'b0;
         m_cnt      <= 0;
         alu_result <= '0;
      end else if (alu_start) begin
         m_pend <= 1'b1;
         m_cnt  <= alu_delay - 1;
         case (alu_sel)
            2'b00:   m_res <= alu_a + alu_b;
            2'b01:   m_res <= alu_a - alu_b;
            2'b10:   m_res <= alu_a & alu_b;
            default: m_res <= alu_a ^ alu_b;
         endcase
      end else if (m_pend) begin
         if (m_cnt == 1) begin
            alu_ready  <= !alu_never;
            alu_result <= m_res;
            m_pend     <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic wait_done(input string tag, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(done0 | done1) && cyc < 40);
      if (!(done0 | done1)) check({tag, "_no_done"}, 32'(done0 | done1), 1);
   endtask

   int cyc;
   int seen_done;
   bit exp_done0 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      rst = 1'b1;
      req0 = 0; a0 = 0; b0 = 0; sel0 = 0;
      req1 = 0; a1 = 0; b1 = 0; sel1 = 0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done0", done0, 0);
      check("rst_done1", done1, 0);
      check("rst_result", result_out, 0);
      check("rst_err", err, 0);
      check("rst_start", alu_start, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single add, ready 3 cycles after start; operand change after grant must not leak in.
      req0 = 1; a0 = 5; b0 = 3; sel0 = 2'b00;
      @(negedge clk);
      check("t1_start", alu_start, 1);
      check("t1_busy", busy, 1);
      check("t1_a", alu_a, 5);
      check("t1_b", alu_b, 3);
      check("t1_sel", alu_sel, 0);
      a0 = 15; b0 = 15;
      wait_done("t1", cyc);
      check("t1_latency", cyc, 4);
      check("t1_done0", done0, 1);
      check("t1_done1", done1, 0);
      check("t1_result", result_out, 8);
      check("t1_err", err, 0);
      check("t1_a_hold", alu_a, 5);
      req0 = 0;
      @(negedge clk);
      check("t1_done_pulse", done0, 0);
      check("t1_idle_busy", busy, 0);
      check("t1_idle_result", result_out, 0);

      // Simultaneous requests straight after reset: requester 0 wins first.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req0 = 1; a0 = 10; b0 = 12; sel0 = 2'b11;
      req1 = 1; a1 = 7;  b1 = 2;  sel1 = 2'b01;
      @(negedge clk);
      check("t2_first_a", alu_a, 10);
      check("t2_first_sel", alu_sel, 3);
      wait_done("t2a", cyc);
      check("t2_done0", done0, 1);
      check("t2_done1_low", done1, 0);
      check("t2_result0", result_out, 6);
      req0 = 0;
      @(negedge clk);
      @(negedge clk);
      check("t2_second_a", alu_a, 7);
      check("t2_second_sel", alu_sel, 1);
      wait_done("t2b", cyc);
      check("t2_done1", done1, 1);
      check("t2_done0_low", done0, 0);
      check("t2_result1", result_out, 5);
      check("t2_err", err, 0);
      req1 = 0;
      @(negedge clk);

      // Both held continuously: grants alternate.
      req0 = 1; a0 = 1; b0 = 1; sel0 = 2'b00;
      req1 = 1; a1 = 6; b1 = 3; sel1 = 2'b10;
      for (int i = 0; i < 4; i++) begin
         wait_done("t3", cyc);
         seen_done = int'(done0);
         check($sformatf("t3_grant%0d", i), 32'(seen_done), 32'(exp_done0[i]));
         check($sformatf("t3_result%0d", i), result_out, 2);
      end
      req0 = 0; req1 = 0;
      @(negedge clk);

      // ALU never answers: timeout after 15 WAIT cycles.
      alu_never = 1'b1;
      req0 = 1; a0 = 2; b0 = 2; sel0 = 2'b00;
      @(negedge clk);
      check("t4_start", alu_start, 1);
      wait_done("t4", cyc);
      check("t4_latency", cyc, 16);
      check("t4_done0", done0, 1);
      check("t4_err", err, 1);
      check("t4_result", result_out, 0);
      req0 = 0;
      @(negedge clk);
      check("t4_busy_after", busy, 0);
      check("t4_err_after", err, 0);

      // Reset during WAIT aborts the operation.
      req1 = 1; a1 = 3; b1 = 3; sel1 = 2'b00;
      @(negedge clk);
      check("t5_start", alu_start, 1);
      repeat (3) @(negedge clk);
      check("t5_in_wait", busy, 1);
      rst = 1'b1; req1 = 0;
      @(negedge clk);
      rst = 1'b0;
      check("t5_busy", busy, 0);
      check("t5_start_low", alu_start, 0);
      check("t5_alu_a", alu_a, 0);
      check("t5_alu_b", alu_b, 0);
      check("t5_alu_sel", alu_sel, 0);
      check("t5_result", result_out, 0);
      check("t5_err", err, 0);
      seen_done = 0;
      repeat (5) begin
         @(negedge clk);
         if (done0 | done1 | busy) seen_done++;
      end
      check("t5_no_done", 32'(seen_done), 0);
      alu_never = 1'b0; alu_delay = 3;
      req1 = 1; a1 = 9; b1 = 4; sel1 = 2'b01;
      @(negedge clk);
      check("t5_issue_a", alu_a, 9);
      wait_done("t5", cyc);
      check("t5_done1", done1, 1);
      check("t5_result_after", result_out, 5);
      check("t5_err_after", err, 0);
      req1 = 0;
      @(negedge clk);

      // Ready on the last permitted WAIT cycle beats the timeout.
      alu_delay = 15;
      req0 = 1; a0 = 4; b0 = 9; sel0 = 2'b00;
      @(negedge clk);
      wait_done("t6", cyc);
      check("t6_latency", cyc, 16);
      check("t6_done0", done0, 1);
      check("t6_err", err, 0);
      check("t6_result", result_out, 13);
      req0 = 0;
      @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
